run_detect_param: RTL

Parametrised run-length detector for a serial bit stream sampled on `i_clk`. It flags when the most recent `RUN_LEN` qualifying samples all share one value, zeros, ones or either, selected at run time. It also counts detection events. It is the generalised successor to the fixed 4-of-a-kind serial detector in the lab FSM set, and it sits directly on a synchronised serial input line.

---
 rtl/run_detect_param.sv | 88 ++++++++
 1 files changed

// File: rtl/run_detect_param.sv
// Run-length detector: flags when the last RUN_LEN qualified samples of i_w agree
// in a polarity enabled by i_mode, and keeps a saturating count of new detections.
//
// state   | meaning
// IDLE    | valid=0, no bit sampled since reset/clear
// RUN(k)  | valid=1, run_cnt=k equal samples of last_bit, k saturates at RUN_LEN
module run_detect_param #(
    parameter int RUN_LEN = 4,
    parameter int DCNT_W  = 8,
    localparam int CNT_W  = $clog2(RUN_LEN + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_w,
    input  logic [1:0]        i_mode,
    output logic              o_match,
    output logic              o_match_val,
    output logic              o_det_pulse,
    output logic [CNT_W-1:0]  o_run_cnt,
    output logic [DCNT_W-1:0] o_det_cnt
);

    localparam logic [CNT_W-1:0]  RUN_MAX = CNT_W'(RUN_LEN);
    localparam logic [DCNT_W-1:0] DET_MAX = {DCNT_W{1'b1}};

    logic              valid;
    logic              last_bit;
    logic [CNT_W-1:0]  run_cnt;
    logic [DCNT_W-1:0] det_cnt;
    logic              det_pulse;

    logic              new_run;
    logic              nxt_bit;
    logic [CNT_W-1:0]  nxt_cnt;
    logic              pol_ok;
    logic              nxt_pol_ok;
    logic              det_evt;

    always_comb begin
        new_run    = ~valid | (i_w != last_bit);
        nxt_bit    = new_run ? i_w : last_bit;
        if (new_run)
            nxt_cnt = CNT_W'(1);
        else if (run_cnt == RUN_MAX)
            nxt_cnt = RUN_MAX;
        else
            nxt_cnt = run_cnt + CNT_W'(1);
        pol_ok     = (~last_bit & i_mode[0]) | (last_bit & i_mode[1]);
        nxt_pol_ok = (~nxt_bit & i_mode[0]) | (nxt_bit & i_mode[1]);
        // Only the step that first reaches RUN_LEN counts; saturated runs stay silent.
        det_evt    = (nxt_cnt == RUN_MAX) & (run_cnt != RUN_MAX) & nxt_pol_ok;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid     <= 1'b0;
            last_bit  <= 1'b0;
            run_cnt   <= '0;
            det_cnt   <= '0;
            det_pulse <= 1'b0;
        end else if (i_clr) begin
            valid     <= 1'b0;
            last_bit  <= 1'b0;
            run_cnt   <= '0;
            det_cnt   <= '0;
            det_pulse <= 1'b0;
        end else if (i_en) begin
            valid     <= 1'b1;
            last_bit  <= nxt_bit;
            run_cnt   <= nxt_cnt;
            det_pulse <= det_evt;
            if (det_evt && (det_cnt != DET_MAX))
                det_cnt <= det_cnt + DCNT_W'(1);
        end else begin
            det_pulse <= 1'b0;
        end
    end

    // Match follows i_mode combinationally so a mode change needs no clock.
    assign o_match     = valid & (run_cnt == RUN_MAX) & pol_ok;
    assign o_match_val = last_bit;
    assign o_det_pulse = det_pulse;
    assign o_run_cnt   = run_cnt;
    assign o_det_cnt   = det_cnt;

endmodule
